// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives the stage-register EN/FLUSH and PC enable for
// data-memory wait, load-use, imem wait and control redirects, and freezes the pipe on halt.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t state, state_n;
  logic   redirect_pend, pend_n;
  logic   data_wait, redir, load_use;
  logic   stall_inc, flush_inc;

  assign data_wait = (mem_dren | mem_dwen) & ~dhit;
  assign redir     = redirect | redirect_pend;
  assign load_use  = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign halted    = (state == HALTED);
  assign fsm_state = state;

  always_comb begin
    state_n   = state;
    pend_n    = redirect_pend;
    flush_inc = 1'b0;
    pc_en     = 1'b0;
    if_en     = 1'b0;
    id_en     = 1'b0;
    ex_en     = 1'b0;
    mem_en    = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    case (state)
      HALTED: state_n = HALTED;
      default: begin
        if (data_wait) begin
          // Whole pipe frozen; a redirect seen now is remembered for the resume cycle.
          state_n = DWAIT;
          pend_n  = redirect_pend | redirect;
        end else begin
          state_n = RUN;
          if (redir) begin
            pc_en    = 1'b1;
            if_en    = 1'b1;
            id_en    = 1'b1;
            ex_en    = 1'b1;
            mem_en   = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            // Keep flushing the fetch slot until the wrong-path fetch has returned.
            pend_n    = ~ihit;
            flush_inc = ihit;
          end else if (load_use || !ihit) begin
            id_en    = 1'b1;
            ex_en    = 1'b1;
            mem_en   = 1'b1;
            id_flush = 1'b1;
          end else begin
            pc_en  = 1'b1;
            if_en  = 1'b1;
            id_en  = 1'b1;
            ex_en  = 1'b1;
            mem_en = 1'b1;
          end
        end
        if (wb_halt) state_n = HALTED;
      end
    endcase
    stall_inc = (state != HALTED) && !pc_en;
    if (!nRST) begin
      pc_en    = 1'b0;
      if_en    = 1'b0;
      id_en    = 1'b0;
      ex_en    = 1'b0;
      mem_en   = 1'b0;
      if_flush = 1'b0;
      id_flush = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= RUN;
      redirect_pend <= 1'b0;
      stall_cycles  <= '0;
      flush_count   <= '0;
    end else begin
      state         <= state_n;
      redirect_pend <= pend_n;
      if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_count != '1))  flush_count  <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic,
// every cycle compared against a rule-level reference model of the controller.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit, dhit, mem_dren, mem_dwen, ex_memread, redirect, wb_halt;
  logic [REG_W-1:0] ex_rt, id_rs, id_rt;
  logic pc_en, if_en, id_en, ex_en, mem_en;
  logic if_flush, id_flush, ex_flush, mem_flush, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // Reference model state: halted flag, pending redirect flag, counters as plain ints.
  bit m_halt, m_pend;
  int m_stall, m_flush;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .redirect(redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .fsm_state(fsm_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {22'd0, pc_en, if_en, id_en, ex_en, mem_en, if_flush, id_flush, ex_flush, mem_flush, halted};
  endfunction

  task automatic idle();
    ihit = 1; dhit = 1; mem_dren = 0; mem_dwen = 0; ex_memread = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; redirect = 0; wb_halt = 0;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance model and DUT together.
  task automatic cycle();
    bit dwait, redir, luse, pc;
    logic [9:0] e;
    @(negedge CLK);
    dwait = !m_halt && (mem_dren || mem_dwen) && !dhit;
    redir = redirect || m_pend;
    luse  = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    // Bit order: pc if id ex mem | if_f id_f ex_f mem_f | halted
    if (m_halt)             e = 10'b00000_0000_1;
    else if (dwait)         e = 10'b00000_0000_0;
    else if (redir)         e = 10'b11111_1100_0;
    else if (luse || !ihit) e = 10'b00111_0100_0;
    else                    e = 10'b11111_0000_0;
    pc = e[9];
    check("outputs", dut_vec(), {22'd0, e});
    check("stall_cycles", 32'(stall_cycles), m_stall);
    check("flush_count", 32'(flush_count), m_flush);
    if (!m_halt) begin
      if (!pc) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (dwait) m_pend = m_pend || redirect;
      else begin
        if (redir && ihit) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        m_pend = redir && !ihit;
      end
      if (wb_halt) m_halt = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse applied between clock edges.
  task automatic do_reset();
    nRST = 0;
    m_halt = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    @(negedge CLK);
    check("reset_outputs", dut_vec(), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    check("reset_flush", 32'(flush_count), 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  initial begin
    idle();
    #1;
    do_reset();

    // Clean run after reset
    repeat (3) cycle();

    // Load-use on id_rs
    ex_memread = 1; ex_rt = 5; id_rs = 5;
    cycle();
    idle();
    cycle();
    check("loaduse_stall", 32'(stall_cycles), 32'd1);

    // Store waiting three cycles on data memory
    do_reset();
    mem_dwen = 1; dhit = 0;
    repeat (3) cycle();
    dhit = 1;
    cycle();
    idle();
    cycle();
    check("dwait_stall", 32'(stall_cycles), 32'd3);

    // Redirect while the fetch is outstanding
    do_reset();
    redirect = 1; ihit = 0;
    cycle();
    redirect = 0;
    cycle();
    ihit = 1;
    cycle();
    cycle();
    check("redir_imem_flush", 32'(flush_count), 32'd1);

    // Redirect arriving during a data wait
    do_reset();
    mem_dren = 1; dhit = 0; redirect = 1;
    cycle();
    redirect = 0;
    cycle();
    dhit = 1;
    cycle();
    idle();
    cycle();
    check("redir_dwait_flush", 32'(flush_count), 32'd1);

    // Halt freezes until reset
    do_reset();
    wb_halt = 1;
    cycle();
    idle();
    redirect = 1; ihit = 0;
    repeat (3) cycle();
    check("halted_sticky", 32'(halted), 32'd1);
    idle();
    do_reset();
    cycle();
    check("halt_cleared", 32'(halted), 32'd0);

    // Counter saturation: hold a long imem wait
    ihit = 0;
    repeat (CNT_MAX + 4) cycle();
    check("stall_saturates", 32'(stall_cycles), CNT_MAX);
    idle();

    // Random traffic with occasional resets, including mid-wait
    for (int i = 0; i < 3000; i++) begin
      ihit       = $urandom_range(0, 3) != 0;
      dhit       = $urandom_range(0, 2) != 0;
      mem_dren   = $urandom_range(0, 5) == 0;
      mem_dwen   = $urandom_range(0, 5) == 0;
      ex_memread = $urandom_range(0, 3) == 0;
      ex_rt      = REG_W'($urandom_range(0, 3));
      id_rs      = REG_W'($urandom_range(0, 3));
      id_rt      = REG_W'($urandom_range(0, 3));
      redirect   = $urandom_range(0, 5) == 0;
      wb_halt    = $urandom_range(0, 200) == 0;
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
